// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, ALU control encodings and the
// payload carried across the EX/MEM boundary.
package core_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_OR  = 4'b0010,
    ALU_AND = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLT = 4'b0101
  } alu_ctrl_e;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rs2_data;
    logic [REGW-1:0] rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } ex_mem_payload_t;

  localparam int PAYLOAD_W = $bits(ex_mem_payload_t);

  // beq is taken on zero, bne on non-zero.
  function automatic logic branch_resolve(input logic branch, input logic zero,
                                          input logic branch_ne);
    return branch & (zero ^ branch_ne);
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready buffer: a main entry drives the outputs, a skid entry
// absorbs one beat under back-pressure so in_ready can be a plain register.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         main_free;

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && !skid_valid;
  // Main can load this edge if it is empty or its beat is being consumed.
  assign main_free = !main_valid || out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: the data registers are reset too, because the visible out_* fields
  // must read zero after reset, not just out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data <= '0;
      skid_data <= '0;
    end else if (!flush) begin
      if (main_free) begin
        if (skid_valid) main_data <= skid_data;
        else if (accept) main_data <= in_data;
      end else if (accept) begin
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX-to-MEM pipeline boundary: buffers ALU results and control for the memory
// stage, resolves beq/bne on accept and counts retired beats.
module ex_mem_stage
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int REGW = core_pkg::REGW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic            in_zero,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [REGW-1:0] in_rd,
  input  logic            in_reg_write,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic            in_branch,
  input  logic            in_branch_ne,
  input  logic [XLEN-1:0] in_pc_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu_result,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [REGW-1:0] out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic [31:0]     retired_count
);

  ex_mem_payload_t in_payload;
  ex_mem_payload_t out_payload;
  logic            accept;
  logic            taken;

  // Writes to x0 are dropped here so later stages never see them.
  assign in_payload = '{
    alu_result: in_alu_result,
    rs2_data:   in_rs2_data,
    rd:         in_rd,
    reg_write:  in_reg_write && (in_rd != '0),
    mem_read:   in_mem_read,
    mem_write:  in_mem_write
  };

  skid_buffer #(
    .W(PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign out_alu_result = out_payload.alu_result;
  assign out_rs2_data   = out_payload.rs2_data;
  assign out_rd         = out_payload.rd;
  assign out_reg_write  = out_payload.reg_write;
  assign out_mem_read   = out_payload.mem_read;
  assign out_mem_write  = out_payload.mem_write;

  assign accept = in_valid && in_ready && !flush;
  assign taken  = branch_resolve(in_branch, in_zero, in_branch_ne);

  // A beat leaving during a flush cycle still counts as retired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_taken  <= 1'b0;
      branch_target <= '0;
      retired_count <= '0;
    end else begin
      branch_taken <= accept && taken;
      if (accept && taken) branch_target <= in_pc_target;
      if (out_valid && out_ready) retired_count <= retired_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random traffic,
// checked by a negedge monitor against a queue-based reference model.
module tb_ex_mem_stage;
  import core_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [XLEN-1:0]   in_alu_result = '0;
  logic              in_zero = 1'b0;
  logic [XLEN-1:0]   in_rs2_data = '0;
  logic [REGW-1:0]   in_rd = '0;
  logic              in_reg_write = 1'b0;
  logic              in_mem_read = 1'b0;
  logic              in_mem_write = 1'b0;
  logic              in_branch = 1'b0;
  logic              in_branch_ne = 1'b0;
  logic [XLEN-1:0]   in_pc_target = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   out_alu_result;
  logic [XLEN-1:0]   out_rs2_data;
  logic [REGW-1:0]   out_rd;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              branch_taken;
  logic [XLEN-1:0]   branch_target;
  logic [31:0]       retired_count;

  ex_mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_result  (in_alu_result),
    .in_zero        (in_zero),
    .in_rs2_data    (in_rs2_data),
    .in_rd          (in_rd),
    .in_reg_write   (in_reg_write),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .in_branch      (in_branch),
    .in_branch_ne   (in_branch_ne),
    .in_pc_target   (in_pc_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_result (out_alu_result),
    .out_rs2_data   (out_rs2_data),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .retired_count  (retired_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state, owned by the monitor.
  ex_mem_payload_t exp_q[$];
  logic [31:0]     exp_cnt = '0;
  logic            exp_bt = 1'b0;
  logic [XLEN-1:0] exp_tgt = '0;

  // Counter override handshake: the stimulus bumps ovr_seq after forcing the
  // DUT counter, and the monitor picks up ovr_val once.
  int          ovr_seq = 0;
  int          ovr_seen = 0;
  logic [31:0] ovr_val = '0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int n;
    logic nbt;
    ex_mem_payload_t act_p;
    ex_mem_payload_t new_p;
    if (ovr_seq != ovr_seen) begin
      exp_cnt  = ovr_val;
      ovr_seen = ovr_seq;
    end
    if (reset) begin
      exp_q.delete();
      exp_cnt = '0;
      exp_bt  = 1'b0;
      exp_tgt = '0;
      check("rst_out_valid", 80'(out_valid), 80'(0));
      check("rst_out_fields", 80'({out_alu_result, out_rs2_data, out_rd, out_reg_write,
                                   out_mem_read, out_mem_write}), 80'(0));
      check("rst_retired", 80'(retired_count), 80'(0));
      check("rst_branch_taken", 80'(branch_taken), 80'(0));
      check("rst_branch_target", 80'(branch_target), 80'(0));
    end else begin
      n = exp_q.size();
      check("out_valid", 80'(out_valid), 80'(n != 0));
      check("in_ready", 80'(in_ready), 80'(n < 2));
      check("retired_count", 80'(retired_count), 80'(exp_cnt));
      check("branch_taken", 80'(branch_taken), 80'(exp_bt));
      check("branch_target", 80'(branch_target), 80'(exp_tgt));
      if (n != 0) begin
        act_p = '{out_alu_result, out_rs2_data, out_rd, out_reg_write, out_mem_read, out_mem_write};
        check("payload", 80'(act_p), 80'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          exp_cnt = exp_cnt + 32'd1;
        end
      end
      nbt = 1'b0;
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && n < 2) begin
        new_p.alu_result = in_alu_result;
        new_p.rs2_data   = in_rs2_data;
        new_p.rd         = in_rd;
        new_p.reg_write  = in_reg_write && (in_rd != 0);
        new_p.mem_read   = in_mem_read;
        new_p.mem_write  = in_mem_write;
        exp_q.push_back(new_p);
        if (in_branch && (in_zero != in_branch_ne)) begin
          nbt     = 1'b1;
          exp_tgt = in_pc_target;
        end
      end
      exp_bt = nbt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic br,
                       input logic ne, input logic zero, input logic [31:0] tgt);
    in_valid      = 1'b1;
    in_alu_result = alu;
    in_rs2_data   = rs2;
    in_rd         = rd;
    in_reg_write  = rw;
    in_mem_read   = mr;
    in_mem_write  = mw;
    in_branch     = br;
    in_branch_ne  = ne;
    in_zero       = zero;
    in_pc_target  = tgt;
  endtask

  // Holds a beat until the edge that accepts it, then drops in_valid.
  task automatic send(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                      input logic br, input logic ne, input logic zero, input logic [31:0] tgt);
    logic acc;
    drive(alu, alu ^ 32'hA5A5_0000, rd, rw, alu[0], alu[1], br, ne, zero, tgt);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    $display("FAIL send_timeout: beat %0h not accepted within 64 cycles", alu);
    $fatal(1, "send timeout");
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Pass-through and x0 masking.
    out_ready = 1'b1;
    send(32'h0000_0005, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    send(32'h0000_0042, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) tick();

    // Back-pressure: A and B fill the buffer, C waits until out_ready returns.
    out_ready = 1'b0;
    send(32'h11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    send(32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    fork
      send(32'h33, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      begin
        repeat (4) tick();
        out_ready = 1'b1;
      end
    join
    repeat (4) tick();

    // Branches: taken beq, untaken bne, taken bne, untaken beq.
    send(32'h1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
    tick();
    send(32'h2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    tick();
    send(32'h3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0300);
    send(32'h4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0400);
    repeat (3) tick();

    // Flush with both entries full and a taken branch offered.
    out_ready = 1'b0;
    send(32'h55, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    send(32'h66, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(32'h77, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0700);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();

    // Random traffic with back-pressure and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      drive($urandom, $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom);
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 65);
      flush     = ($urandom_range(0, 99) < 4);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    // Counter wrap: park one beat, preset the counter, then retire it.
    out_ready = 1'b0;
    send(32'h99, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    force dut.retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count;
    ovr_val   = 32'hFFFF_FFFF;
    ovr_seq   = ovr_seq + 1;
    out_ready = 1'b1;
    repeat (3) tick();

    // Async reset between edges with the buffer full.
    out_ready = 1'b0;
    send(32'hAA, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0A00);
    send(32'hBB, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    send(32'hCC, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
